// File: rtl/rca_config_pkg.sv
// Shared RCA configuration: request field widths, bitstream layout constants
// and the dispatch FSM state encoding.
package rca_config;

   localparam int          OU_ID_W     = 3;
   localparam int          GRID_SLOT_W = 2;
   localparam logic [31:0] BS_BASE     = 32'h0100_0000;
   localparam logic [31:0] BS_STRIDE   = 32'h0004_0000;
   localparam logic [31:0] BS_BYTES    = 32'h0003_A000;

   // Layout of the low bits of a popped queue word.
   typedef struct packed {
      logic [OU_ID_W-1:0]     ou_id;
      logic [GRID_SLOT_W-1:0] grid_slot;
   } pr_queue_inputs_t;

   typedef enum logic [2:0] {
      PR_IDLE   = 3'd0,
      PR_AR     = 3'd1,
      PR_R      = 3'd2,
      PR_CALC   = 3'd3,
      PR_CMD    = 3'd4,
      PR_WAIT   = 3'd5,
      PR_NOTIFY = 3'd6
   } pr_dispatch_state_t;

endpackage

// File: rtl/pr_watchdog.sv
// Clear/enable up-counter with a terminal-count flag; used as the loader
// watchdog when PR_DISPATCH_TIMEOUT_EN is defined.
module pr_watchdog #(
   parameter int WIDTH    = 20,
   parameter int TERMINAL = 1048575
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tc
);

   logic [WIDTH-1:0] r_count;

   // Counter: clear has priority over increment.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= {WIDTH{1'b0}};
      end else if (i_clear) begin
         r_count <= {WIDTH{1'b0}};
      end else if (i_en) begin
         r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r_count <= r_count;
      end
   end

   assign o_tc = (r_count == WIDTH'(TERMINAL));

endmodule

// File: rtl/pr_dispatch_controller.sv
// Pops PR requests from the RCA queue over AXI-lite, issues bitstream load
// commands and reports completed slots. Optional watchdog: PR_DISPATCH_TIMEOUT_EN.
module pr_dispatch_controller #(
   parameter int          OU_ID_W        = rca_config::OU_ID_W,
   parameter int          GRID_SLOT_W    = rca_config::GRID_SLOT_W,
   parameter logic [31:0] BS_BASE        = rca_config::BS_BASE,
   parameter logic [31:0] BS_STRIDE      = rca_config::BS_STRIDE,
   parameter logic [31:0] BS_BYTES       = rca_config::BS_BYTES,
   parameter int          TIMEOUT_CYCLES = 2**20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   pr_request_pending,
   output logic [1:0]             m_axi_araddr,
   output logic                   m_axi_arvalid,
   input  logic                   m_axi_arready,
   input  logic [31:0]            m_axi_rdata,
   input  logic                   m_axi_rvalid,
   output logic                   m_axi_rready,
   output logic [31:0]            dma_addr,
   output logic [31:0]            dma_len,
   output logic                   dma_valid,
   input  logic                   dma_ready,
   input  logic                   dma_done,
   input  logic                   dma_error,
   output logic                   slot_done,
   output logic [OU_ID_W-1:0]     slot_done_ou_id,
   output logic [GRID_SLOT_W-1:0] slot_done_grid_slot,
   output logic                   busy,
   output logic                   err
);

   import rca_config::*;

   localparam int IDX_W = OU_ID_W + GRID_SLOT_W;

   pr_dispatch_state_t     r_state;
   pr_dispatch_state_t     w_next_state;
   logic [OU_ID_W-1:0]     r_ou_id;
   logic [GRID_SLOT_W-1:0] r_grid_slot;
   logic [IDX_W-1:0]       w_idx;
   logic [31-IDX_W:0]      w_unused_rdata;
   logic                   w_timeout;

   logic                   w_arvalid;
   logic                   w_rready;
   logic                   w_dma_valid;
   logic                   w_slot_done;
   logic                   w_busy;
   logic                   w_err;
   logic [31:0]            w_dma_addr;
   logic [31:0]            w_dma_len;
   logic [OU_ID_W-1:0]     w_slot_ou_id;
   logic [GRID_SLOT_W-1:0] w_slot_grid_slot;

   assign m_axi_araddr   = 2'b10;
   assign w_idx          = {r_ou_id, r_grid_slot};
   assign w_unused_rdata = m_axi_rdata[31:IDX_W];

`ifdef PR_DISPATCH_TIMEOUT_EN
   pr_watchdog #(
      .WIDTH    ($clog2(TIMEOUT_CYCLES)),
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .i_clear (r_state != PR_WAIT),
      .i_en    (r_state == PR_WAIT),
      .o_tc    (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= PR_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; a load error outranks done, done outranks the watchdog.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         PR_IDLE:   if (enable && pr_request_pending) w_next_state = PR_AR;
                    else                              w_next_state = PR_IDLE;
         PR_AR:     if (m_axi_arready) w_next_state = PR_R;
                    else               w_next_state = PR_AR;
         PR_R:      if (m_axi_rvalid) w_next_state = PR_CALC;
                    else              w_next_state = PR_R;
         PR_CALC:   w_next_state = PR_CMD;
         PR_CMD:    if (dma_ready) w_next_state = PR_WAIT;
                    else           w_next_state = PR_CMD;
         PR_WAIT:   if (dma_error)      w_next_state = PR_IDLE;
                    else if (dma_done)  w_next_state = PR_NOTIFY;
                    else if (w_timeout) w_next_state = PR_IDLE;
                    else                w_next_state = PR_WAIT;
         PR_NOTIFY: w_next_state = PR_IDLE;
         default:   w_next_state = PR_IDLE;
      endcase
   end

   // Output next-values, derived from the upcoming state so the flops below
   // present them in the same cycle the FSM enters that state.
   always_comb begin
      w_arvalid   = (w_next_state == PR_AR);
      w_rready    = (w_next_state == PR_R);
      w_dma_valid = (w_next_state == PR_CMD);
      w_slot_done = (w_next_state == PR_NOTIFY);
      w_busy      = (w_next_state != PR_IDLE);
      if ((r_state == PR_WAIT) && (dma_error || (!dma_done && w_timeout))) begin
         w_err = 1'b1;
      end else begin
         w_err = err;
      end
      if (r_state == PR_CALC) begin
         w_dma_addr = BS_BASE + (32'(w_idx) * BS_STRIDE);
         w_dma_len  = BS_BYTES;
      end else begin
         w_dma_addr = dma_addr;
         w_dma_len  = dma_len;
      end
      if (w_next_state == PR_NOTIFY) begin
         w_slot_ou_id     = r_ou_id;
         w_slot_grid_slot = r_grid_slot;
      end else begin
         w_slot_ou_id     = slot_done_ou_id;
         w_slot_grid_slot = slot_done_grid_slot;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_axi_arvalid       <= 1'b0;
         m_axi_rready        <= 1'b0;
         dma_valid           <= 1'b0;
         dma_addr            <= 32'h0000_0000;
         dma_len             <= 32'h0000_0000;
         slot_done           <= 1'b0;
         slot_done_ou_id     <= {OU_ID_W{1'b0}};
         slot_done_grid_slot <= {GRID_SLOT_W{1'b0}};
         busy                <= 1'b0;
         err                 <= 1'b0;
      end else begin
         m_axi_arvalid       <= w_arvalid;
         m_axi_rready        <= w_rready;
         dma_valid           <= w_dma_valid;
         dma_addr            <= w_dma_addr;
         dma_len             <= w_dma_len;
         slot_done           <= w_slot_done;
         slot_done_ou_id     <= w_slot_ou_id;
         slot_done_grid_slot <= w_slot_grid_slot;
         busy                <= w_busy;
         err                 <= w_err;
      end
   end

   // Capture the popped request; upper rdata bits are discarded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ou_id     <= {OU_ID_W{1'b0}};
         r_grid_slot <= {GRID_SLOT_W{1'b0}};
      end else if ((r_state == PR_R) && m_axi_rvalid) begin
         r_ou_id     <= m_axi_rdata[IDX_W-1:GRID_SLOT_W];
         r_grid_slot <= m_axi_rdata[GRID_SLOT_W-1:0];
      end else begin
         r_ou_id     <= r_ou_id;
         r_grid_slot <= r_grid_slot;
      end
   end

endmodule

// File: tb/tb_pr_dispatch_controller.sv
// Self-checking bench for pr_dispatch_controller: table of requests driven
// through AXI-lite/DMA handshakes, with queued expected commands and slot events.
module tb_pr_dispatch_controller;

   localparam int OUT_DONE = 0;
   localparam int OUT_ERR  = 1;
   localparam int OUT_BOTH = 2;
   localparam int OUT_RST  = 3;
   localparam int OUT_TMO  = 4;

`ifdef PR_DISPATCH_TIMEOUT_EN
   localparam int TB_TIMEOUT_CYCLES = 16;
`else
   localparam int TB_TIMEOUT_CYCLES = 2**20;
`endif

   typedef struct {
      logic [2:0]  ou;
      logic [1:0]  gs;
      int          ar_dly;
      int          dr_dly;
      logic        drop_en;
      int          outcome;
      logic [31:0] exp_addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        pr_request_pending;
   logic [1:0]  m_axi_araddr;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [31:0] dma_addr;
   logic [31:0] dma_len;
   logic        dma_valid;
   logic        dma_ready;
   logic        dma_done;
   logic        dma_error;
   logic        slot_done;
   logic [2:0]  slot_done_ou_id;
   logic [1:0]  slot_done_grid_slot;
   logic        busy;
   logic        err;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_cmd_q[$];
   logic [4:0]  exp_slot_q[$];
   logic        exp_err;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   pr_dispatch_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT_CYCLES)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .enable              (enable),
      .pr_request_pending  (pr_request_pending),
      .m_axi_araddr        (m_axi_araddr),
      .m_axi_arvalid       (m_axi_arvalid),
      .m_axi_arready       (m_axi_arready),
      .m_axi_rdata         (m_axi_rdata),
      .m_axi_rvalid        (m_axi_rvalid),
      .m_axi_rready        (m_axi_rready),
      .dma_addr            (dma_addr),
      .dma_len             (dma_len),
      .dma_valid           (dma_valid),
      .dma_ready           (dma_ready),
      .dma_done            (dma_done),
      .dma_error           (dma_error),
      .slot_done           (slot_done),
      .slot_done_ou_id     (slot_done_ou_id),
      .slot_done_grid_slot (slot_done_grid_slot),
      .busy                (busy),
      .err                 (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input vec_t v, input logic more);
      int          n;
      logic [31:0] rd;
      logic [4:0]  got_slot;
      rca_config::pr_queue_inputs_t q;
      enable             = 1'b1;
      pr_request_pending = 1'b1;
      n = 0;
      while (!m_axi_arvalid && n < 20) begin
         tick();
         n++;
      end
      chk("arvalid_seen", 32'(m_axi_arvalid), 32'd1);
      chk("araddr", 32'(m_axi_araddr), 32'd2);
      for (int i = 0; i < v.ar_dly; i++) tick();
      chk("arvalid_held", 32'(m_axi_arvalid), 32'd1);
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready      = 1'b0;
      pr_request_pending = more;
      if (v.drop_en) enable = 1'b0;
      chk("arvalid_drop", 32'(m_axi_arvalid), 32'd0);
      chk("rready_up", 32'(m_axi_rready), 32'd1);

      q.ou_id     = v.ou;
      q.grid_slot = v.gs;
      rd          = $urandom();
      rd[4:0]     = q;
      exp_cmd_q.push_back(v.exp_addr);
      if (v.outcome == OUT_DONE) exp_slot_q.push_back(q);
      m_axi_rdata  = rd;
      m_axi_rvalid = 1'b1;
      tick();
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = $urandom();
      chk("rready_drop", 32'(m_axi_rready), 32'd0);

      n = 0;
      while (!dma_valid && n < 20) begin
         tick();
         n++;
      end
      chk("dma_valid_seen", 32'(dma_valid), 32'd1);
      chk("dma_addr_first", dma_addr, exp_cmd_q[0]);
      for (int i = 0; i < v.dr_dly; i++) tick();
      chk("dma_valid_held", 32'(dma_valid), 32'd1);
      chk("dma_addr", dma_addr, exp_cmd_q.pop_front());
      chk("dma_len", dma_len, 32'h0003_A000);
      chk("no_extra_ar", 32'(m_axi_arvalid), 32'd0);
      dma_ready = 1'b1;
      tick();
      dma_ready = 1'b0;
      chk("dma_valid_drop", 32'(dma_valid), 32'd0);
      chk("busy_wait", 32'(busy), 32'd1);

      case (v.outcome)
         OUT_TMO: begin
            n = 0;
            while (busy && n < 40) begin
               tick();
               n++;
            end
            exp_err = 1'b1;
            chk("timeout_cycles", 32'(n), 32'd16);
            chk("tmo_no_slot", 32'(slot_done), 32'd0);
         end
         OUT_RST: begin
            tick();
            tick();
            rst = 1'b0;
            tick();
            rst     = 1'b1;
            exp_err = 1'b0;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_dma_valid", 32'(dma_valid), 32'd0);
            chk("rst_slot", 32'(slot_done), 32'd0);
            dma_done = 1'b1;
            tick();
            dma_done = 1'b0;
            chk("rst_no_slot", 32'(slot_done), 32'd0);
         end
         default: begin
            tick();
            tick();
            chk("no_early_slot", 32'(slot_done), 32'd0);
            dma_done  = (v.outcome != OUT_ERR);
            dma_error = (v.outcome != OUT_DONE);
            tick();
            dma_done  = 1'b0;
            dma_error = 1'b0;
            if (v.outcome == OUT_DONE) begin
               chk("slot_done", 32'(slot_done), 32'd1);
               got_slot = exp_slot_q.pop_front();
               chk("slot_ou_id", 32'(slot_done_ou_id), 32'(got_slot[4:2]));
               chk("slot_grid", 32'(slot_done_grid_slot), 32'(got_slot[1:0]));
               chk("ar_after_slot", 32'(m_axi_arvalid), 32'd0);
               tick();
               chk("slot_pulse_end", 32'(slot_done), 32'd0);
               chk("busy_idle", 32'(busy), 32'd0);
            end else begin
               exp_err = 1'b1;
               chk("err_no_slot", 32'(slot_done), 32'd0);
               chk("err_busy", 32'(busy), 32'd0);
            end
         end
      endcase
      chk("err", 32'(err), 32'(exp_err));
   endtask

   initial begin
      rst                = 1'b0;
      enable             = 1'b0;
      pr_request_pending = 1'b0;
      m_axi_arready      = 1'b0;
      m_axi_rdata        = 32'h0000_0000;
      m_axi_rvalid       = 1'b0;
      dma_ready          = 1'b0;
      dma_done           = 1'b0;
      dma_error          = 1'b0;
      exp_err            = 1'b0;

      vecs.push_back('{3'd3, 2'd1, 0, 0, 1'b0, OUT_DONE, 32'h0134_0000});
      vecs.push_back('{3'd0, 2'd0, 5, 7, 1'b1, OUT_DONE, 32'h0100_0000});
      vecs.push_back('{3'd7, 2'd3, 1, 2, 1'b0, OUT_ERR,  32'h017C_0000});
      vecs.push_back('{3'd5, 2'd2, 0, 1, 1'b0, OUT_DONE, 32'h0158_0000});
      vecs.push_back('{3'd1, 2'd3, 2, 0, 1'b0, OUT_BOTH, 32'h011C_0000});
      vecs.push_back('{3'd6, 2'd1, 0, 0, 1'b0, OUT_RST,  32'h0164_0000});
`ifdef PR_DISPATCH_TIMEOUT_EN
      vecs.push_back('{3'd4, 2'd2, 0, 0, 1'b0, OUT_TMO,  32'h0148_0000});
`endif
      vecs.push_back('{3'd2, 2'd0, 3, 3, 1'b0, OUT_DONE, 32'h0120_0000});

      tick();
      tick();
      chk("rst_araddr", 32'(m_axi_araddr), 32'd2);
      chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
      chk("rst_rready", 32'(m_axi_rready), 32'd0);
      chk("rst_dma_valid0", 32'(dma_valid), 32'd0);
      chk("rst_dma_addr", dma_addr, 32'h0000_0000);
      chk("rst_dma_len", dma_len, 32'h0000_0000);
      chk("rst_slot_done", 32'(slot_done), 32'd0);
      chk("rst_busy0", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b1;

      // Pending without enable must not start a pop.
      pr_request_pending = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("gated_arvalid", 32'(m_axi_arvalid), 32'd0);
      chk("gated_busy", 32'(busy), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         run_req(vecs[i], (i < vecs.size() - 1));
      end

      for (int i = 0; i < 3; i++) tick();
      chk("final_idle", 32'(busy), 32'd0);
      chk("final_no_ar", 32'(m_axi_arvalid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pr_dispatch_controller.md
# pr_dispatch_controller

Hardware consumer for the RCA partial-reconfiguration request queue. Sits on the read side of the queue's AXI-lite slave as an AXI-lite read master. It pops one request at a time ({ou_id, grid_slot}), computes the partial-bitstream location for that pair, and hands it to the bitstream loader (DMA→ICAP) over a valid/ready command channel. When the load completes, it reports the reconfigured slot back to the RCA. This replaces software servicing of the pr_request_pending interrupt.

## Interface
- OU_ID_W, 3, width of ou_id field (rdata bits [OU_ID_W+GRID_SLOT_W-1:GRID_SLOT_W])
- GRID_SLOT_W, 2, width of grid_slot field (rdata bits [GRID_SLOT_W-1:0])
- BS_BASE, 32'h0100_0000, byte address of bitstream 0
- BS_STRIDE, 32'h0004_0000, byte spacing between bitstreams
- BS_BYTES, 32'h0003_A000, bitstream length in bytes
- TIMEOUT_CYCLES, 2**20, loader watchdog limit (only with PR_DISPATCH_TIMEOUT_EN)
- clk  in  1  clock, Taiga clock domain
- rst  in  1  reset, synchronous, active-low
- enable  in  1  dispatch permitted; sampled only in IDLE
- pr_request_pending  in  1  queue non-empty
- m_axi_araddr  out  2  fixed 2'b10 (pop address)
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address accepted
- m_axi_rdata  in  32  popped request
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data accept
- dma_addr  out  32  bitstream byte address
- dma_len  out  32  bitstream byte length
- dma_valid  out  1  load command valid
- dma_ready  in  1  load command accepted
- dma_done  in  1  load complete pulse
- dma_error  in  1  load failed pulse
- slot_done  out  1  one-cycle pulse: slot reconfigured
- slot_done_ou_id  out  OU_ID_W  ou_id for the slot_done event
- slot_done_grid_slot  out  GRID_SLOT_W  grid_slot for the slot_done event
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky error; cleared only by reset

## Operation
- The FSM has seven states: IDLE, AR, R, CALC, CMD, WAIT, NOTIFY.
- IDLE: if enable && pr_request_pending, go to AR.
- AR: arvalid=1, held until arready. arready → R.
- R: rready=1. rvalid → capture ou_id and grid_slot from rdata, then go to CALC. Upper rdata bits are ignored.
- CALC: idx = {ou_id, grid_slot}. dma_addr = BS_BASE + idx*BS_STRIDE, computed modulo 2^32 (overflow wraps silently). dma_len = BS_BYTES. Next state is CMD.
- CMD: dma_valid=1. dma_addr and dma_len are stable while valid. dma_ready → WAIT.
- WAIT: dma_done → NOTIFY. dma_error → set err, go to IDLE, no slot_done.
  - If dma_done and dma_error are high in the same cycle, dma_error wins.
- NOTIFY: slot_done=1 for one cycle with the captured ids, then IDLE.
- Only one request is in flight at a time. The queue is never peeked; it is always popped.
- Deasserting enable mid-operation does not abort. The current request completes.
- Reset mid-operation: the FSM returns to IDLE and the captured request is lost.
  - If the pop has already occurred, the request is not restored to the queue. Software must re-issue it.
- Reset values: all outputs 0, except m_axi_araddr=2'b10. The FSM resets to IDLE.

## Timing
- IDLE→arvalid: 1 cycle after pending && enable are sampled.
- arvalid, dma_valid and rready are registered outputs. They deassert the cycle after their handshake completes.
- No combinational path exists from any input to any output.
- Minimum request latency, from pending seen to slot_done: 6 cycles plus the queue's AR/R latency and the loader latency.
- rvalid arriving with rready low cannot occur, because rready is held for all of R.
- slot_done_* are valid only while slot_done=1. They hold their last values otherwise.

## Configuration
- PR_DISPATCH_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WAIT and increments every WAIT cycle.
  - Reaching TIMEOUT_CYCLES-1 without dma_done or dma_error sets err and returns to IDLE.
  - A dma_done in the same cycle as the timeout takes priority over the timeout.
- PR_DISPATCH_TIMEOUT_EN undefined: WAIT waits indefinitely, no counter is instantiated, and TIMEOUT_CYCLES is unused.

## Structure
- rca_config package: OU_ID_W, GRID_SLOT_W, BS_BASE, BS_STRIDE, BS_BYTES as shared constants.
  - The pr_queue_inputs_t field widths must match OU_ID_W and GRID_SLOT_W.
- rca_config package: the pr_dispatch_state_t enum.
- One sub-module, pr_watchdog: clear/enable counter with a terminal-count output. It is instantiated only under PR_DISPATCH_TIMEOUT_EN.

## Test plan
- Single request: rdata={ou_id=3, grid_slot=1}, idx=13 → dma_addr=0x0134_0000, dma_len=0x0003_A000, then one slot_done pulse with 3/1 after dma_done.
- Back-to-back: three queued requests with enable=1 → three pops, three sequential DMA commands, no overlap.
  - The second AR is issued only after the first slot_done.
- Backpressure: arready delayed 5 cycles and dma_ready delayed 7 cycles → arvalid and dma_valid held with stable addr/len; exactly one pop.
- Error: dma_error in WAIT → err=1, no slot_done, return to IDLE; the next request is still dispatched.
  - Simultaneous dma_done and dma_error → err=1.
- Timeout (PR_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=16): dma_done never arrives → err set after 16 WAIT cycles.
- Reset in WAIT: rst=0 for one cycle → busy=0, dma_valid=0, slot_done never pulses; the next pending request starts cleanly.
